// File: rtl/sort_mem_slave.sv
// Word-addressed memory responder behind the sort circuit's ar/r/aw/w/b channels.
// Independent read and write engines, programmable read latency, side port for preload/observe.
//
// Read engine state | meaning
//   R_IDLE          | ar_ready high, waiting for a read address
//   R_WAIT          | latency counter running down to the sample edge
//   R_RESP          | r_valid high, r_data/r_resp held until r_ready
// Write engine state | meaning
//   W_COLLECT        | aw and w accepted independently until both are held
//   W_RESP           | b_valid high, b_resp held until b_ready
module sort_mem_slave #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1,
    parameter int DEPTH     = 16,
    parameter int READ_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ar_valid,
    input  logic [ADDR_WDTH-1:0] ar_address,
    output logic                 ar_ready,
    output logic                 r_valid,
    output logic [DATA_WDTH-1:0] r_data,
    output logic [RESP_WDTH-1:0] r_resp,
    input  logic                 r_ready,
    input  logic                 aw_valid,
    input  logic [ADDR_WDTH-1:0] aw_address,
    output logic                 aw_ready,
    input  logic                 w_valid,
    input  logic [DATA_WDTH-1:0] w_data,
    output logic                 w_ready,
    output logic                 b_valid,
    output logic [RESP_WDTH-1:0] b_resp,
    input  logic                 b_ready,
    input  logic                 init_we,
    input  logic [ADDR_WDTH-1:0] init_addr,
    input  logic [DATA_WDTH-1:0] init_data,
    output logic [DATA_WDTH-1:0] dbg_data
);

    localparam int                   CNT_W       = $clog2(READ_LAT) + 1;
    localparam logic [CNT_W-1:0]     LAT_LOAD    = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
    localparam logic [ADDR_WDTH:0]   DEPTH_L     = (ADDR_WDTH + 1)'(DEPTH);
    localparam logic [RESP_WDTH-1:0] RESP_OKAY   = '0;
    localparam logic [RESP_WDTH-1:0] RESP_SLVERR = RESP_WDTH'(1);
    localparam int                   WORDS       = 2 ** ADDR_WDTH;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic       {W_COLLECT, W_RESP}      wr_state_t;

    logic [DATA_WDTH-1:0] r_mem [WORDS];

    rd_state_t            r_rd_state;
    rd_state_t            w_rd_state_nxt;
    logic [CNT_W-1:0]     r_rd_cnt;
    logic [ADDR_WDTH-1:0] r_rd_addr;
    logic [DATA_WDTH-1:0] r_rd_data;
    logic [RESP_WDTH-1:0] r_rd_resp;
    logic                 w_ar_hs;
    logic                 w_rd_sample;

    wr_state_t            r_wr_state;
    wr_state_t            w_wr_state_nxt;
    logic                 r_aw_held;
    logic                 r_w_held;
    logic [ADDR_WDTH-1:0] r_wr_addr;
    logic [DATA_WDTH-1:0] r_wr_data;
    logic [RESP_WDTH-1:0] r_wr_resp;
    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_commit;

    logic                 w_rd_in_range;
    logic                 w_wr_in_range;
    logic                 w_init_in_range;

    // Range checks are unsigned and one bit wider so DEPTH == 2**ADDR_WDTH fits.
    assign w_rd_in_range   = {1'b0, r_rd_addr} < DEPTH_L;
    assign w_wr_in_range   = {1'b0, r_wr_addr} < DEPTH_L;
    assign w_init_in_range = {1'b0, init_addr} < DEPTH_L;

    // ---------------- read engine ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_ar_hs        = 1'b0;
        w_rd_sample    = 1'b0;
        ar_ready       = 1'b0;
        r_valid        = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (ar_valid) begin
                    w_ar_hs        = 1'b1;
                    w_rd_state_nxt = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_rd_cnt == '0) begin
                    w_rd_sample    = 1'b1;
                    w_rd_state_nxt = R_RESP;
                end
            end
            R_RESP: begin
                r_valid = 1'b1;
                if (r_ready) begin
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_cnt  <= '0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
            r_rd_resp <= RESP_OKAY;
        end else begin
            if (w_ar_hs) begin
                r_rd_addr <= ar_address;
                r_rd_cnt  <= LAT_LOAD;
            end else if (r_rd_state == R_WAIT && r_rd_cnt != '0) begin
                r_rd_cnt <= r_rd_cnt - CNT_ONE;
            end
            // Sampled with a non-blocking read, so a same-edge commit yields the old word.
            if (w_rd_sample) begin
                if (w_rd_in_range) begin
                    r_rd_data <= r_mem[r_rd_addr];
                    r_rd_resp <= RESP_OKAY;
                end else begin
                    r_rd_data <= '0;
                    r_rd_resp <= RESP_SLVERR;
                end
            end
        end
    end

    assign r_data = r_rd_data;
    assign r_resp = r_rd_resp;

    // ---------------- write engine ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= W_COLLECT;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_aw_hs        = 1'b0;
        w_w_hs         = 1'b0;
        w_commit       = 1'b0;
        aw_ready       = 1'b0;
        w_ready        = 1'b0;
        b_valid        = 1'b0;
        case (r_wr_state)
            W_COLLECT: begin
                aw_ready = !r_aw_held;
                w_ready  = !r_w_held;
                w_aw_hs  = aw_valid && !r_aw_held;
                w_w_hs   = w_valid && !r_w_held;
                if (r_aw_held && r_w_held) begin
                    w_commit       = 1'b1;
                    w_wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (b_ready) begin
                    w_wr_state_nxt = W_COLLECT;
                end
            end
            default: w_wr_state_nxt = W_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_resp <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_wr_addr <= aw_address;
            end
            if (w_w_hs) begin
                r_w_held  <= 1'b1;
                r_wr_data <= w_data;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_wr_resp <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign b_resp = r_wr_resp;

    // ---------------- storage ----------------
    // The commit assignment comes last so it overrides a same-address side-port write.
    always_ff @(posedge clk) begin
        if (init_we && w_init_in_range) begin
            r_mem[init_addr] <= init_data;
        end
        if (w_commit && w_wr_in_range && !rst) begin
            r_mem[r_wr_addr] <= r_wr_data;
        end
    end

    assign dbg_data = w_init_in_range ? r_mem[init_addr] : '0;

endmodule

// File: tb/tb_sort_mem_slave.sv
// Directed bench for sort_mem_slave: latency, stalls, range errors, collisions, reset and an
// insertion sort driven through the bus with random stalls.
module tb_sort_mem_slave;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int RW = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance: DEPTH=12, READ_LAT=1
    logic          rst;
    logic          ar_valid, ar_ready, r_valid, r_ready;
    logic [AW-1:0] ar_address;
    logic [DW-1:0] r_data;
    logic [RW-1:0] r_resp;
    logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic [AW-1:0] aw_address;
    logic [DW-1:0] w_data;
    logic [RW-1:0] b_resp;
    logic          init_we;
    logic [AW-1:0] init_addr;
    logic [DW-1:0] init_data, dbg_data;

    // latency instance: DEPTH=16, READ_LAT=4, read side only
    logic          l4_rst;
    logic          l4_ar_valid, l4_ar_ready, l4_r_valid, l4_r_ready;
    logic [AW-1:0] l4_ar_address;
    logic [DW-1:0] l4_r_data;
    logic [RW-1:0] l4_r_resp, l4_b_resp;
    logic          l4_aw_ready, l4_w_ready, l4_b_valid;
    logic          l4_init_we;
    logic [AW-1:0] l4_init_addr;
    logic [DW-1:0] l4_init_data, l4_dbg_data;

    int n_checks = 0;
    int n_errors = 0;

    sort_mem_slave #(
        .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW), .DEPTH(12), .READ_LAT(1)
    ) u_dut (
        .clk(clk), .rst(rst),
        .ar_valid(ar_valid), .ar_address(ar_address), .ar_ready(ar_ready),
        .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_ready(r_ready),
        .aw_valid(aw_valid), .aw_address(aw_address), .aw_ready(aw_ready),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .dbg_data(dbg_data)
    );

    sort_mem_slave #(
        .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW), .DEPTH(16), .READ_LAT(4)
    ) u_dut_lat4 (
        .clk(clk), .rst(l4_rst),
        .ar_valid(l4_ar_valid), .ar_address(l4_ar_address), .ar_ready(l4_ar_ready),
        .r_valid(l4_r_valid), .r_data(l4_r_data), .r_resp(l4_r_resp), .r_ready(l4_r_ready),
        .aw_valid(1'b0), .aw_address('0), .aw_ready(l4_aw_ready),
        .w_valid(1'b0), .w_data('0), .w_ready(l4_w_ready),
        .b_valid(l4_b_valid), .b_resp(l4_b_resp), .b_ready(1'b0),
        .init_we(l4_init_we), .init_addr(l4_init_addr), .init_data(l4_init_data),
        .dbg_data(l4_dbg_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        init_we   = 1'b1;
        init_addr = a;
        init_data = d;
        tick();
        init_we   = 1'b0;
    endtask

    task automatic dbg_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        init_addr = a;
        #1;
        chk(tag, 64'(dbg_data), 64'(exp));
    endtask

    task automatic ar_send(input logic [AW-1:0] a);
        logic rdy;
        int   n;
        ar_valid   = 1'b1;
        ar_address = a;
        n = 0;
        do begin
            rdy = ar_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        ar_valid = 1'b0;
        chk("ar_accept", 64'(rdy), 64'h1);
    endtask

    task automatic aw_send(input logic [AW-1:0] a);
        logic rdy;
        int   n;
        aw_valid   = 1'b1;
        aw_address = a;
        n = 0;
        do begin
            rdy = aw_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        aw_valid = 1'b0;
        chk("aw_accept", 64'(rdy), 64'h1);
    endtask

    task automatic w_send(input logic [DW-1:0] d);
        logic rdy;
        int   n;
        w_valid = 1'b1;
        w_data  = d;
        n = 0;
        do begin
            rdy = w_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        w_valid = 1'b0;
        chk("w_accept", 64'(rdy), 64'h1);
    endtask

    // Edges elapsed until r_valid shows; it is seen by the interface one edge later.
    task automatic wait_r(output int lat);
        lat = 0;
        while (r_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        chk("r_valid_seen", 64'(r_valid), 64'h1);
    endtask

    task automatic r_accept();
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
    endtask

    task automatic b_take(output logic [RW-1:0] resp);
        int n;
        n = 0;
        while (b_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("b_valid_seen", 64'(b_valid), 64'h1);
        resp    = b_resp;
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input int ar_dly, input int r_dly,
                      output logic [DW-1:0] data, output logic [RW-1:0] resp);
        int lat;
        repeat (ar_dly) tick();
        ar_send(a);
        wait_r(lat);
        data = r_data;
        resp = r_resp;
        repeat (r_dly) tick();
        r_accept();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int aw_dly,
                      input int w_dly, input int b_dly, output logic [RW-1:0] resp);
        fork
            begin
                repeat (aw_dly) tick();
                aw_send(a);
            end
            begin
                repeat (w_dly) tick();
                w_send(d);
            end
        join
        repeat (b_dly) tick();
        b_take(resp);
    endtask

    task automatic l4_rd(input logic [AW-1:0] a, output logic [DW-1:0] data, output int seen);
        int lat;
        l4_ar_valid   = 1'b1;
        l4_ar_address = a;
        chk("l4_ar_ready", 64'(l4_ar_ready), 64'h1);
        tick();
        l4_ar_valid = 1'b0;
        lat = 0;
        while (l4_r_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        seen = lat + 1;
        data = l4_r_data;
        l4_r_ready = 1'b1;
        tick();
        l4_r_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] data, key, v;
        logic [RW-1:0] resp;
        logic          ok;
        int            lat, j;
        logic          done;
        logic [DW-1:0] sort_init [8];
        logic [DW-1:0] sort_exp  [8];

        sort_init = '{32'd5, 32'd1, 32'd4, 32'd2, 32'd8, 32'd0, 32'd3, 32'd7};
        sort_exp  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd7, 32'd8};

        rst = 1'b1; l4_rst = 1'b1;
        ar_valid = 1'b0; ar_address = '0; r_ready = 1'b0;
        aw_valid = 1'b0; aw_address = '0; w_valid = 1'b0; w_data = '0; b_ready = 1'b0;
        init_we = 1'b0; init_addr = '0; init_data = '0;
        l4_ar_valid = 1'b0; l4_ar_address = '0; l4_r_ready = 1'b0;
        l4_init_we = 1'b0; l4_init_addr = '0; l4_init_data = '0;
        tick();
        tick();
        rst = 1'b0; l4_rst = 1'b0;

        chk("rst_ar_ready", 64'(ar_ready), 64'h1);
        chk("rst_aw_ready", 64'(aw_ready), 64'h1);
        chk("rst_w_ready",  64'(w_ready),  64'h1);
        chk("rst_r_valid",  64'(r_valid),  64'h0);
        chk("rst_b_valid",  64'(b_valid),  64'h0);
        chk("rst_r_data",   64'(r_data),   64'h0);
        chk("rst_r_resp",   64'(r_resp),   64'h0);
        chk("rst_b_resp",   64'(b_resp),   64'h0);

        // preload and read back with r_ready stalled
        init_wr(4'd3, 32'h0000_00AA);
        ar_send(4'd3);
        wait_r(lat);
        chk("rd3_latency", 64'(lat + 1), 64'd2);
        chk("rd3_data", 64'(r_data), 64'hAA);
        chk("rd3_resp", 64'(r_resp), 64'h0);
        ok = 1'b1;
        repeat (3) begin
            tick();
            if (r_valid !== 1'b1 || r_data !== 32'hAA) ok = 1'b0;
        end
        chk("rd3_hold", 64'(ok), 64'h1);
        r_accept();
        chk("rd3_r_drop", 64'(r_valid), 64'h0);

        // w leads aw by two cycles
        wr(4'd5, 32'h0000_1234, 2, 0, 0, resp);
        chk("wr5_b_resp", 64'(resp), 64'h0);
        ok = 1'b1;
        repeat (3) begin
            tick();
            if (b_valid !== 1'b0) ok = 1'b0;
        end
        chk("wr5_single_b", 64'(ok), 64'h1);
        dbg_chk("wr5_dbg", 4'd5, 32'h0000_1234);

        // out-of-range accesses against DEPTH=12
        init_wr(4'd11, 32'h0000_0055);
        wr(4'd13, 32'hDEAD_0013, 0, 0, 1, resp);
        chk("wr13_b_resp", 64'(resp), 64'h1);
        wr(4'd12, 32'hDEAD_0012, 1, 0, 0, resp);
        chk("wr12_b_resp", 64'(resp), 64'h1);
        wr(4'd11, 32'h0000_0066, 0, 1, 0, resp);
        chk("wr11_b_resp", 64'(resp), 64'h0);
        dbg_chk("oor_dbg5", 4'd5, 32'h0000_1234);
        dbg_chk("oor_dbg13", 4'd13, 32'h0);
        rd(4'd13, 0, 0, data, resp);
        chk("rd13_data", 64'(data), 64'h0);
        chk("rd13_resp", 64'(resp), 64'h1);
        rd(4'd12, 0, 1, data, resp);
        chk("rd12_data", 64'(data), 64'h0);
        chk("rd12_resp", 64'(resp), 64'h1);
        rd(4'd11, 1, 0, data, resp);
        chk("rd11_data", 64'(data), 64'h66);
        chk("rd11_resp", 64'(resp), 64'h0);

        // read sample and write commit to address 7 on the same edge
        init_wr(4'd7, 32'h0000_0011);
        ar_valid = 1'b1; ar_address = 4'd7;
        aw_valid = 1'b1; aw_address = 4'd7;
        w_valid  = 1'b1; w_data     = 32'h0000_0022;
        chk("col_readies", 64'({ar_ready, aw_ready, w_ready}), 64'h7);
        tick();
        ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
        wait_r(lat);
        chk("col_rd_latency", 64'(lat + 1), 64'd2);
        chk("col_old_data", 64'(r_data), 64'h11);
        r_accept();
        b_take(resp);
        chk("col_b_resp", 64'(resp), 64'h0);
        rd(4'd7, 0, 0, data, resp);
        chk("col_new_data", 64'(data), 64'h22);

        // side-port write coinciding with a commit to the same address
        aw_valid = 1'b1; aw_address = 4'd9;
        w_valid  = 1'b1; w_data     = 32'h00C0_FFEE;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        init_wr(4'd9, 32'h0000_0BAD);
        b_take(resp);
        chk("init_col_b_resp", 64'(resp), 64'h0);
        dbg_chk("init_col_dbg9", 4'd9, 32'h00C0_FFEE);

        // READ_LAT=4 instance: latency, then reset two edges after a handshake
        l4_init_we = 1'b1; l4_init_addr = 4'd2; l4_init_data = 32'h0000_BEEF;
        tick();
        l4_init_we = 1'b0;
        l4_rd(4'd2, data, lat);
        chk("l4_latency", 64'(lat), 64'd5);
        chk("l4_data", 64'(data), 64'hBEEF);
        l4_ar_valid = 1'b1; l4_ar_address = 4'd2;
        tick();
        l4_ar_valid = 1'b0;
        tick();
        l4_rst = 1'b1;
        tick();
        l4_rst = 1'b0;
        chk("l4_rst_ar_ready", 64'(l4_ar_ready), 64'h1);
        chk("l4_rst_r_valid", 64'(l4_r_valid), 64'h0);
        ok = 1'b1;
        repeat (6) begin
            tick();
            if (l4_r_valid !== 1'b0) ok = 1'b0;
        end
        chk("l4_rst_no_resp", 64'(ok), 64'h1);
        l4_rd(4'd2, data, lat);
        chk("l4_post_rst_latency", 64'(lat), 64'd5);
        chk("l4_post_rst_data", 64'(data), 64'hBEEF);

        // insertion sort over words 0..7 through the bus with random stalls
        for (int k = 0; k < 8; k++) init_wr(4'(k), sort_init[k]);
        for (int i = 1; i < 8; i++) begin
            rd(4'(i), $urandom_range(0, 2), $urandom_range(0, 3), key, resp);
            j    = i - 1;
            done = 1'b0;
            while (j >= 0 && !done) begin
                rd(4'(j), $urandom_range(0, 2), $urandom_range(0, 3), v, resp);
                if (v > key) begin
                    wr(4'(j + 1), v, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 2), resp);
                    chk("sort_shift_b_resp", 64'(resp), 64'h0);
                    j--;
                end else begin
                    done = 1'b1;
                end
            end
            wr(4'(j + 1), key, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2), resp);
            chk("sort_insert_b_resp", 64'(resp), 64'h0);
        end
        for (int k = 0; k < 8; k++) dbg_chk("sort_scan", 4'(k), sort_exp[k]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sort_mem_slave.md
Name: sort_mem_slave

Overview:
- Word-addressed memory responder that sits directly downstream of the sort circuit's memory interface.
- Serves the five valid/ready channels (ar, r, aw, w, b) that the sort circuit drives.
- Independent read and write engines, programmable read latency, SLVERR on out-of-range addresses.
- A side port preloads the array and observes it, for system benches and bring-up.

Parameters:
- ADDR_WDTH, 4, address width; array holds 2**ADDR_WDTH words.
- DATA_WDTH, 32, word width.
- RESP_WDTH, 1, response width; 0 = OKAY, 1 = SLVERR (zero-extended if wider).
- DEPTH, 16, number of implemented words (1..2**ADDR_WDTH). Addresses >= DEPTH are out of range.
- READ_LAT, 1, cycles between ar handshake and r_valid assertion (>= 1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ar_valid  in  1  read address valid.
- ar_address  in  ADDR_WDTH  read address.
- ar_ready  out  1  read address accept.
- r_valid  out  1  read data valid.
- r_data  out  DATA_WDTH  read data.
- r_resp  out  RESP_WDTH  read response.
- r_ready  in  1  read data accept.
- aw_valid  in  1  write address valid.
- aw_address  in  ADDR_WDTH  write address.
- aw_ready  out  1  write address accept.
- w_valid  in  1  write data valid.
- w_data  in  DATA_WDTH  write data.
- w_ready  out  1  write data accept.
- b_valid  out  1  write response valid.
- b_resp  out  RESP_WDTH  write response.
- b_ready  in  1  write response accept.
- init_we  in  1  side-port write enable.
- init_addr  in  ADDR_WDTH  side-port address.
- init_data  in  DATA_WDTH  side-port write data.
- dbg_data  out  DATA_WDTH  combinational array[init_addr]; 0 if init_addr >= DEPTH.

Behaviour:
- Reset (rst=1 at an edge): both engines return to idle. Registered outputs after that edge: ar_ready=1, aw_ready=1, w_ready=1, r_valid=0, b_valid=0, r_data=0, r_resp=0, b_resp=0. Array contents are not reset. Reset mid-transaction abandons it silently; no response is issued.
- A handshake occurs on an edge where valid and ready are both 1. Outputs, once valid, are held stable until the matching ready is seen.

Read FSM R_IDLE -> R_WAIT -> R_RESP:
- R_IDLE: ar_ready=1. On the ar handshake, latch the address, load the counter with READ_LAT-1, and go to R_WAIT (ar_ready=0).
- R_WAIT: decrement each cycle. At 0, sample array[addr] into r_data with r_resp=0 (or r_data=0, r_resp=1 if addr >= DEPTH), and go to R_RESP.
- Result: r_valid is first seen READ_LAT+1 cycles after the ar handshake edge.
- R_RESP: r_valid=1. On r_ready, go to R_IDLE; the next ar handshake is possible one cycle later.

Write FSM W_COLLECT -> W_RESP:
- W_COLLECT: aw_ready=1 until aw is accepted; w_ready=1 until w is accepted. aw and w are accepted independently, in either order or in the same cycle.
- Once both are held, the commit edge writes array[addr]=data (only if addr < DEPTH), sets b_resp to 0 or 1 accordingly, and enters W_RESP.
- When aw and w arrive in the same cycle, commit happens on the following edge.
- W_RESP: b_valid=1, aw_ready=0, w_ready=0. On b_ready, return to W_COLLECT.

Collisions:
- Read sample and write commit to the same address on the same edge: the read returns the OLD value.
- init_we writes array[init_addr] on any edge; it is ignored if init_addr >= DEPTH. If it coincides with a commit to the same address, the commit wins.
- Read and write engines run fully concurrently; there is no ordering between channels.
- Address width arithmetic: the range comparison is unsigned. The counter is $clog2(READ_LAT)+1 bits wide.

Test Plan:
- Preload via init_we: array[3]=0x0000_00AA. ar_address=3 with READ_LAT=1 -> r_valid at the 2nd edge after handshake, r_data=0xAA, r_resp=0. r_ready held low 3 cycles -> r_data and r_valid stable throughout.
- w_valid with 0x1234 two cycles before aw_valid, aw_address=5 -> single commit, b_valid with b_resp=0. dbg_data at init_addr=5 reads 0x1234.
- DEPTH=12, write to address 13 -> b_resp=1 and array unchanged. Read from address 13 -> r_data=0, r_resp=1.
- Concurrent read of address 7 (old value 0x11) whose sample edge equals a write commit of 0x22 to 7 -> r_data=0x11. Subsequent read -> 0x22.
- READ_LAT=4: ar handshake at cycle 10 -> r_valid first high at cycle 15. Assert rst at cycle 12 -> r_valid stays 0 and ar_ready=1 after the reset edge.
- Drive the insertion-sort access pattern on 8 words [5,1,4,2,8,0,3,7] with random ready/valid stalls -> final dbg scan reads [0,1,2,3,4,5,7,8] and every b_resp=0.
